serial_adder: RTL
=================

// Module: serial_adder
//
// PURPOSE
//  Bit-serial multi-bit adder built around a single fullAdder cell and a carry flip-flop.
//  Accepts two WIDTH-bit operands plus carry-in via a valid/ready handshake.
//  Processes one bit per clock, LSB first, and presents the WIDTH-bit sum and carry-out
//  with a valid/ready handshake. It is the sequential stage that consumes the
//  combinational full-adder cell. Area is traded for WIDTH cycles of latency.
//
// PARAMETERS
//  WIDTH   8   operand/sum width in bits; legal values are WIDTH >= 2.
//
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous reset, active-high
//  in_valid   in   1      a/b/cin valid
//  in_ready   out  1      block can accept operands; asserted only in IDLE
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in
//  out_valid  out  1      sum/cout valid; asserted only in DONE
//  out_ready  in   1      consumer accepts the result
//  sum        out  WIDTH  result bits, registered
//  cout       out  1      final carry, registered
//  busy       out  1      asserted while in RUN
//
// BEHAVIOUR
//  - Result: {cout,sum} = a + b + cin, exact, (WIDTH+1) bits.
//  - Datapath: exactly one fullAdder instance computes each bit. No '+' operator on the datapath.
//  - rst asserted (any time, including mid-RUN): the current operation is aborted immediately.
//    * State = IDLE; shift registers, carry FF and bit counter all = 0.
//    * Outputs: sum = 0, cout = 0, out_valid = 0, busy = 0, in_ready = 1.
//  - FSM has three states: IDLE, RUN, DONE.
//    * IDLE: in_ready = 1.
//      - Edge with in_valid = 1: capture a and b into shift registers, carry FF <= cin, counter <= 0, go to RUN.
//      - Otherwise stay in IDLE.
//    * RUN: in_ready = 0, busy = 1. Each edge:
//      - The fullAdder takes a_sh[0], b_sh[0] and the carry FF.
//      - Its sum bit shifts into the MSB of the sum shift register (shift right).
//      - a_sh and b_sh shift right; carry FF <= adder carry; counter++.
//      - On the edge where counter == WIDTH-1: load sum/cout from the final values and go to DONE.
//    * DONE: out_valid = 1; sum and cout are held stable.
//      - Edge with out_ready = 1: go to IDLE.
//      - Otherwise hold (backpressure is unbounded).
//  - Latency: out_valid rises exactly WIDTH cycles after the accept edge.
//    Minimum op-to-op interval is WIDTH+2 cycles.
//  - in_ready and out_valid are decoded from state only.
//    No accept can occur on the same edge as the output handshake.
//  - a, b and cin are sampled only on the accept edge. Changes during RUN or DONE are ignored.
//  - in_valid while in RUN or DONE has no effect. Nothing is queued.
//  - After the output handshake, sum and cout keep the last result until the next DONE.
//    They are meaningful only while out_valid = 1.
//  - Wrap-around: overflow appears only in cout; sum is the result modulo 2^WIDTH.
//
// TESTING
//  1. a=8'h5A, b=8'h3C, cin=0 -> out_valid 8 cycles after accept; sum=8'h96, cout=0.
//  2. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
//  3. Hold out_ready=0 for 5 cycles in DONE -> out_valid=1 and sum/cout stable; in_ready=0;
//     in_valid pulses ignored; IDLE one cycle after out_ready=1.
//  4. Assert rst at bit 3 of a RUN -> all outputs take reset values immediately.
//     After release, a=8'h01, b=8'h01 -> sum=8'h02.
//  5. Hold in_valid=1 and out_ready=1 with 1000 random vectors -> one accept every 10 cycles;
//     every {cout,sum} matches the a+b+cin model.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built around one full-adder cell
// and a carry flip-flop. Operands come in through a valid/ready handshake.
// The sum is formed one bit per clock, LSB first. The result {cout,sum}
// goes out through a second valid/ready handshake.

// full_adder: combinational one-bit full-adder cell.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   // The bit counter only has to reach WIDTH-1. WIDTH >= 2 keeps this at least one bit wide.
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] s_sh;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic             fa_s;
   logic             fa_co;
   logic [WIDTH-1:0] s_sh_nxt;
   logic             last_bit;

   // The single adder cell. Every result bit passes through it.
   full_adder u_fa (
      .a  (a_sh[0]),
      .b  (b_sh[0]),
      .ci (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   // The new sum bit enters at the MSB. After WIDTH shifts the LSB has reached bit 0.
   assign s_sh_nxt = {fa_s, s_sh[WIDTH-1:1]};
   assign last_bit = (cnt == LAST_BIT);

   // Handshake and status flags depend on the state alone, so the input and output handshakes never share an edge.
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state == RUN);

   // State register. Reset aborts any operation in progress and returns to IDLE.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
      state_nxt = state;
      unique case (state)
         IDLE:    if (in_valid)  state_nxt = RUN;
         RUN:     if (last_bit)  state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // Datapath: capture on accept, shift one bit per RUN cycle, latch the result on the last bit.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: every datapath register is cleared by reset, so sum/cout read 0 right after an abort.
      if (rst) begin
         a_sh  <= '0;
         b_sh  <= '0;
         s_sh  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= cin;
                  cnt   <= '0;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               s_sh  <= s_sh_nxt;
               carry <= fa_co;
               cnt   <= cnt + CW'(1);
               if (last_bit) begin
                  sum  <= s_sh_nxt;
                  cout <= fa_co;
               end
            end
            default: begin
               // DONE: the result stays on sum/cout until the consumer takes it.
            end
         endcase
      end
   end

endmodule
